spi_bus_arbiter: RTL

- Shares one SPI bus (spi_sclk, spi_mosi, spi_miso, spi_cs_n) between NUM_REQ requesters using round-robin arbitration.
- Sequences each granted request as one full-duplex SPI mode 0 word transfer (CPOL=0, CPHA=0, MSB first), and returns the received word tagged with the requester id.
- Drives the master side of the spi_if bus.

---
 rtl/spi_bus_arbiter_if.sv | 21 ++
 rtl/spi_bus_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter_if.sv
// rtl/spi_bus_arbiter_if.sv - SPI bus signals shared between the arbiter and one slave
interface spi_bus_arbiter_if;
   logic spi_sclk;
   logic spi_mosi;
   logic spi_miso;
   logic spi_cs_n;

   modport master (
      output spi_sclk,
      output spi_mosi,
      output spi_cs_n,
      input  spi_miso
   );

   modport slave (
      input  spi_sclk,
      input  spi_mosi,
      input  spi_cs_n,
      output spi_miso
   );
endinterface

// File: rtl/spi_bus_arbiter.sv
// rtl/spi_bus_arbiter.sv - round-robin arbiter sequencing SPI mode 0 word transfers
module spi_bus_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4,
   localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic                      rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic [ID_W-1:0]           rsp_id,
   output logic                      busy,
   spi_bus_arbiter_if.master         spi
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   state_t state;
   state_t state_next;

   logic [CNT_W-1:0]  half_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   // Holds only the bits still to be sent; the current bit already sits in mosi.
   logic [DATA_W-2:0] tx_sr;
   logic [DATA_W-1:0] rx_sr;
   logic [ID_W-1:0]   id_q;
   logic [ID_W-1:0]   last;
   logic              sclk;
   logic              mosi;
   logic              cs_n;

   logic              grant_any;
   logic              hi_found;
   logic [ID_W-1:0]   hi_idx;
   logic [ID_W-1:0]   lo_idx;
   logic [ID_W-1:0]   grant_idx;
   logic [DATA_W-1:0] grant_data;
   logic              half_done;
   logic              last_bit;

   assign spi.spi_sclk = sclk;
   assign spi.spi_mosi = mosi;
   assign spi.spi_cs_n = cs_n;

   assign half_done = (half_cnt == HALF_LAST);
   assign last_bit  = (bit_cnt == BIT_LAST);
   assign busy      = (state != IDLE);

   // Round robin: the lowest valid index above last wins, else the lowest valid overall.
   always_comb begin
      grant_any = 1'b0;
      hi_found  = 1'b0;
      hi_idx    = '0;
      lo_idx    = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            grant_any = 1'b1;
            lo_idx    = ID_W'(i);
            if (ID_W'(i) > last) begin
               hi_found = 1'b1;
               hi_idx   = ID_W'(i);
            end
         end
      end
      grant_idx = hi_found ? hi_idx : lo_idx;
   end

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            grant_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_next = state;
      req_ready  = '0;
      case (state)
         IDLE: begin
            if (grant_any) begin
               req_ready  = NUM_REQ'(1) << grant_idx;
               state_next = SETUP;
            end
         end
         SETUP: if (half_done) state_next = SHIFT;
         SHIFT: if (half_done && !sclk && last_bit) state_next = HOLD;
         HOLD:  if (half_done) state_next = GAP;
         GAP:   if (half_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         half_cnt  <= '0;
         bit_cnt   <= '0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         id_q      <= '0;
         last      <= ID_W'(NUM_REQ - 1);
         sclk      <= 1'b0;
         mosi      <= 1'b0;
         cs_n      <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
      end else begin
         state     <= state_next;
         rsp_valid <= 1'b0;
         half_cnt  <= half_done ? '0 : half_cnt + 1'b1;
         case (state)
            IDLE: begin
               half_cnt <= '0;
               if (grant_any) begin
                  tx_sr   <= grant_data[DATA_W-2:0];
                  mosi    <= grant_data[DATA_W-1];
                  rx_sr   <= '0;
                  id_q    <= grant_idx;
                  last    <= grant_idx;
                  cs_n    <= 1'b0;
                  bit_cnt <= '0;
               end
            end
            SETUP: begin
               if (half_done) sclk <= 1'b1;
            end
            SHIFT: begin
               if (half_done) begin
                  if (sclk) begin
                     rx_sr <= {rx_sr[DATA_W-2:0], spi.spi_miso};
                     sclk  <= 1'b0;
                     // After the final bit mosi keeps presenting the LSB.
                     if (!last_bit) begin
                        mosi  <= tx_sr[DATA_W-2];
                        tx_sr <= tx_sr << 1;
                     end
                  end else if (!last_bit) begin
                     sclk    <= 1'b1;
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (half_done) begin
                  cs_n      <= 1'b1;
                  mosi      <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_data  <= rx_sr;
                  rsp_id    <= id_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
